// File: rtl/soc_system_pio_led_ext_if.sv
// Avalon-MM slave bus bundle for the LED/GPIO output PIO.
// The master drives address and strobes; the slave returns zero-wait readdata.
interface soc_system_pio_led_ext_if;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address,
      output chipselect,
      output write_n,
      output writedata,
      input  readdata
   );

   modport slave (
      input  address,
      input  chipselect,
      input  write_n,
      input  writedata,
      output readdata
   );
endinterface

// File: rtl/soc_system_pio_led_ext.sv
// Output PIO with atomic SET/CLEAR/TOGGLE writes and a per-bit hardware blink generator
// (prescaler tick plus half-period counter) driving board LEDs or GPIO outputs.
module soc_system_pio_led_ext #(
   parameter int               WIDTH        = 10,
   parameter logic [WIDTH-1:0] RESET_VALUE  = 10'h2AA,
   parameter int               PRESCALE     = 50000,
   parameter int               PERIOD_W     = 16,
   parameter int               RESET_PERIOD = 250
) (
   input  logic                            clk,
   input  logic                            reset_n,
   soc_system_pio_led_ext_if.slave         bus,
   output logic [WIDTH-1:0]                out_port,
   output logic                            blink_phase
);

   localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [WIDTH-1:0]    data_out_q, data_out_d;
   logic [WIDTH-1:0]    blink_en_q, blink_en_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
   logic [PERIOD_W-1:0] tick_cnt_q, tick_cnt_d;
   logic                phase_q, phase_d;

   logic             wr;
   logic             tick;
   logic [WIDTH-1:0] wdata;

   assign wr    = bus.chipselect & ~bus.write_n;
   assign wdata = bus.writedata[WIDTH-1:0];
   assign tick  = (pre_cnt_q == PRE_W'(PRESCALE - 1));

   always_comb begin
      data_out_d = data_out_q;
      blink_en_d = blink_en_q;
      period_d   = period_q;
      pre_cnt_d  = tick ? '0 : pre_cnt_q + PRE_W'(1);
      tick_cnt_d = tick_cnt_q;
      phase_d    = phase_q;

      // A stopped generator (period 0) parks at phase 1 while the prescaler free-runs.
      if (period_q == '0) begin
         tick_cnt_d = '0;
         phase_d    = 1'b1;
      end else if (tick) begin
         if (tick_cnt_q == period_q - PERIOD_W'(1)) begin
            tick_cnt_d = '0;
            phase_d    = ~phase_q;
         end else begin
            tick_cnt_d = tick_cnt_q + PERIOD_W'(1);
         end
      end

      if (wr) begin
         case (bus.address)
            3'd0: data_out_d = wdata;
            3'd1: data_out_d = data_out_q | wdata;
            3'd2: data_out_d = data_out_q & ~wdata;
            3'd3: data_out_d = data_out_q ^ wdata;
            3'd4: blink_en_d = wdata;
            // Reprogramming the period restarts the generator and overrides any pending toggle.
            3'd5: begin
               period_d   = bus.writedata[PERIOD_W-1:0];
               pre_cnt_d  = '0;
               tick_cnt_d = '0;
               phase_d    = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_out_q <= RESET_VALUE;
         blink_en_q <= '0;
         period_q   <= PERIOD_W'(RESET_PERIOD);
         pre_cnt_q  <= '0;
         tick_cnt_q <= '0;
         phase_q    <= 1'b1;
      end else begin
         data_out_q <= data_out_d;
         blink_en_q <= blink_en_d;
         period_q   <= period_d;
         pre_cnt_q  <= pre_cnt_d;
         tick_cnt_q <= tick_cnt_d;
         phase_q    <= phase_d;
      end
   end

   always_comb begin
      bus.readdata = '0;
      case (bus.address)
         3'd0, 3'd1, 3'd2, 3'd3: bus.readdata = 32'(data_out_q);
         3'd4:                   bus.readdata = 32'(blink_en_q);
         3'd5:                   bus.readdata = 32'(period_q);
         3'd6:                   bus.readdata = {31'd0, phase_q};
         default:                ;
      endcase
   end

   // Blink-enabled bits are gated low during the off phase; all others show data directly.
   assign out_port    = data_out_q & ~(blink_en_q & {WIDTH{~phase_q}});
   assign blink_phase = phase_q;

endmodule

// File: tb/tb_soc_system_pio_led_ext.sv
// Self-checking bench for soc_system_pio_led_ext: directed scenarios with literal expectations
// followed by randomized bus traffic, all compared every cycle against a cycle-count model.
module tb_soc_system_pio_led_ext;

   localparam int WIDTH    = 10;
   localparam int PRESCALE = 4;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic [WIDTH-1:0] out_port;
   logic             blink_phase;

   int checks   = 0;
   int failures = 0;

   soc_system_pio_led_ext_if bus();

   soc_system_pio_led_ext #(
      .WIDTH        (10),
      .RESET_VALUE  (10'h2AA),
      .PRESCALE     (4),
      .PERIOD_W     (8),
      .RESET_PERIOD (2)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .bus         (bus.slave),
      .out_port    (out_port),
      .blink_phase (blink_phase)
   );

   always #5 clk = ~clk;

   // Reference model: phase is derived from clocks elapsed since the last generator restart.
   logic [WIDTH-1:0] m_data;
   logic [WIDTH-1:0] m_blink;
   logic [7:0]       m_period;
   int               m_c;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_data   <= 10'h2AA;
         m_blink  <= '0;
         m_period <= 8'd2;
         m_c      <= 0;
      end else begin
         m_c <= m_c + 1;
         if (bus.chipselect && !bus.write_n) begin
            case (bus.address)
               3'd0: m_data <= bus.writedata[9:0];
               3'd1: m_data <= m_data | bus.writedata[9:0];
               3'd2: m_data <= m_data & ~bus.writedata[9:0];
               3'd3: m_data <= m_data ^ bus.writedata[9:0];
               3'd4: m_blink <= bus.writedata[9:0];
               3'd5: begin
                  m_period <= bus.writedata[7:0];
                  m_c      <= 0;
               end
               default: ;
            endcase
         end
      end
   end

   function automatic logic expPhase();
      if (m_period == 8'd0) return 1'b1;
      return ((m_c / (PRESCALE * int'(m_period))) % 2) == 0;
   endfunction

   function automatic logic [WIDTH-1:0] expOut();
      logic ph;
      logic [WIDTH-1:0] r;
      ph = expPhase();
      for (int i = 0; i < WIDTH; i++) r[i] = m_blink[i] ? (m_data[i] && ph) : m_data[i];
      return r;
   endfunction

   function automatic logic [31:0] expRead(input logic [2:0] a);
      case (a)
         3'd0, 3'd1, 3'd2, 3'd3: return 32'(m_data);
         3'd4:                   return 32'(m_blink);
         3'd5:                   return 32'(m_period);
         3'd6:                   return 32'(expPhase());
         default:                return 32'd0;
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   always @(negedge clk) begin
      if (reset_n) begin
         checkOutput("model_out_port", 32'(out_port), 32'(expOut()));
         checkOutput("model_blink_phase", 32'(blink_phase), 32'(expPhase()));
         checkOutput("model_readdata", bus.readdata, expRead(bus.address));
      end
   end

   task automatic busIdle();
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
      bus.address    = 3'd0;
      bus.writedata  = 32'd0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic writeReg(input logic [2:0] a, input logic [31:0] d);
      bus.address    = a;
      bus.writedata  = d;
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b0;
      @(posedge clk);
      #1;
      busIdle();
   endtask

   task automatic readReg(input string name, input logic [2:0] a, input logic [31:0] exp);
      bus.address    = a;
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b1;
      @(negedge clk);
      #1;
      checkOutput(name, bus.readdata, exp);
      @(posedge clk);
      #1;
      busIdle();
   endtask

   task automatic peek();
      @(negedge clk);
      #1;
   endtask

   task automatic applyStimulus(input int n);
      logic [2:0]  a;
      logic        cs;
      logic        wn;
      logic [31:0] d;
      for (int i = 0; i < n; i++) begin
         a  = 3'($urandom_range(0, 7));
         cs = ($urandom_range(0, 3) != 0);
         wn = $urandom_range(0, 1) == 1;
         d  = $urandom;
         if (a == 3'd5 && !wn) begin
            if ($urandom_range(0, 7) != 0) wn = 1'b1;
            else d = {$urandom_range(0, 255) > 200 ? 24'hABCDEF : 24'h0, 8'($urandom_range(0, 3))};
         end
         bus.address    = a;
         bus.chipselect = cs;
         bus.write_n    = wn;
         bus.writedata  = d;
         @(posedge clk);
         #1;
      end
      busIdle();
   endtask

   logic [23:0] samples;

   initial begin
      busIdle();
      #12 reset_n = 1'b1;
      #1;

      checkOutput("reset_out_port", 32'(out_port), 32'h2AA);
      checkOutput("reset_blink_phase", 32'(blink_phase), 32'h1);
      @(posedge clk);
      #1;
      readReg("reset_read_data", 3'd0, 32'h2AA);
      readReg("reset_read_period", 3'd5, 32'h2);
      readReg("reset_read_status", 3'd6, 32'h1);

      writeReg(3'd0, 32'h000);
      readReg("read_after_data", 3'd0, 32'h000);
      writeReg(3'd1, 32'h00F);
      readReg("read_after_set", 3'd1, 32'h00F);
      writeReg(3'd2, 32'h003);
      readReg("read_after_clear", 3'd2, 32'h00C);
      writeReg(3'd3, 32'h101);
      readReg("read_after_toggle", 3'd3, 32'h10D);
      checkOutput("out_after_toggle", 32'(out_port), 32'h10D);

      writeReg(3'd5, 32'd2);
      writeReg(3'd0, 32'h3FF);
      writeReg(3'd4, 32'h001);
      for (int i = 0; i < 24; i++) begin
         peek();
         samples[i] = out_port[0];
         checkOutput("blink_upper_bits", 32'(out_port[9:1]), 32'h1FF);
         @(posedge clk);
         #1;
      end
      checkOutput("blink_bit0_pattern", 32'(samples), 32'h3FC03F);

      writeReg(3'd5, 32'd2);
      idle(15);
      peek();
      checkOutput("phase_before_restart", 32'(blink_phase), 32'h0);
      writeReg(3'd5, 32'd3);
      peek();
      checkOutput("phase_after_restart", 32'(blink_phase), 32'h1);
      idle(11);
      peek();
      checkOutput("phase_before_toggle", 32'(blink_phase), 32'h1);
      idle(1);
      peek();
      checkOutput("phase_at_toggle", 32'(blink_phase), 32'h0);
      idle(1);

      writeReg(3'd5, 32'd0);
      writeReg(3'd4, 32'h3FF);
      writeReg(3'd0, 32'hFFFFF155);
      readReg("data_width_mask", 3'd0, 32'h155);
      readReg("status_stopped", 3'd6, 32'h1);
      for (int i = 0; i < 12; i++) begin
         peek();
         checkOutput("stopped_out_port", 32'(out_port), 32'h155);
         @(posedge clk);
         #1;
      end

      writeReg(3'd5, 32'd1);
      writeReg(3'd4, 32'h3FF);
      writeReg(3'd1, 32'h3FF);
      idle(3);
      peek();
      checkOutput("phase_before_reset", 32'(blink_phase), 32'h0);
      #2 reset_n = 1'b0;
      #1;
      checkOutput("async_reset_out_port", 32'(out_port), 32'h2AA);
      checkOutput("async_reset_phase", 32'(blink_phase), 32'h1);
      @(posedge clk);
      #3 reset_n = 1'b1;
      @(posedge clk);
      #1;
      readReg("reset_blink_en", 3'd4, 32'h0);
      readReg("reset_period", 3'd5, 32'h2);
      idle(4);
      peek();
      checkOutput("restart_phase_high", 32'(blink_phase), 32'h1);
      idle(1);
      peek();
      checkOutput("restart_phase_low", 32'(blink_phase), 32'h0);
      idle(1);

      applyStimulus(600);
      idle(20);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
